// File: rtl/skew_buf_db.sv
// Double-buffered DIM x DIM matrix store that streams rows as a diagonal skew:
// lane r emits row r delayed by r beats. Ping-pong banks allow fill during stream.

module skew_buf_db_lane #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int LANE    = 0,
  parameter int TW      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          clr,
  input  logic [TW-1:0]                 tidx,
  input  logic                          rvld,
  input  logic [DIM-1:0][BITS_AB-1:0]   row,
  output logic [BITS_AB-1:0]            aout
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  logic [TW-1:0]      col;
  logic [BITS_AB-1:0] nxt;

  assign col = tidx - TW'(LANE);

  // Lane r sees column t-r; outside the diagonal window the lane is idle (zero).
  always_comb begin
    nxt = '0;
    if (rvld && (tidx >= TW'(LANE)) && (col < TW'(DIM)))
      nxt = row[col[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    aout <= '0;
    else if (clr)  aout <= '0;
    else if (load) aout <= nxt;
  end
endmodule

module skew_buf_db #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                wr_en,
  input  logic [$clog2(DIM)-1:0]              wr_row,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  wr_data,
  input  logic                                wr_commit,
  output logic                                wr_ready,
  input  logic                                start,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Aout,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          ready_cnt
);
  localparam int TW = $clog2(2*DIM);
  localparam logic [TW-1:0] LAST = TW'(2*DIM-2);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_READY, B_STREAM} bst_t;
  typedef enum logic {S_IDLE, S_STREAM} fsm_t;

  logic [DIM-1:0][BITS_AB-1:0] mem [2][DIM];
  logic [DIM-1:0]              mask [2];
  bst_t                        bst [2];
  bst_t                        bst_n [2];
  fsm_t                        fsm;
  logic [TW-1:0]               t;
  logic                        fp, rd_ptr, cur;
  logic                        wr_acc, cm_acc, start_acc, fin, adv, ld, sel;
  logic [TW-1:0]               tidx;
  logic [1:0]                  rc_n;

  assign wr_ready  = (bst[fp] == B_EMPTY) || (bst[fp] == B_FILLING);
  assign wr_acc    = wr_en & wr_ready;
  assign cm_acc    = wr_commit & wr_ready;
  assign start_acc = (fsm == S_IDLE) && start && (ready_cnt != 2'd0);
  assign fin       = (fsm == S_STREAM) && en && (t == LAST);
  assign adv       = (fsm == S_STREAM) && en && (t != LAST);
  assign ld        = start_acc | adv;
  // Commits alternate banks, so streaming in commit order is a simple toggle.
  assign sel       = start_acc ? rd_ptr : cur;
  assign tidx      = start_acc ? '0 : t + TW'(1);

  always_comb begin
    bst_n[0] = bst[0];
    bst_n[1] = bst[1];
    if (wr_acc && bst[fp] == B_EMPTY) bst_n[fp] = B_FILLING;
    if (cm_acc)                       bst_n[fp] = B_READY;
    if (start_acc)                    bst_n[rd_ptr] = B_STREAM;
    if (fin)                          bst_n[cur] = B_EMPTY;
    rc_n = 2'(bst_n[0] == B_READY) + 2'(bst_n[1] == B_READY);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[fp][wr_row] <= wr_data;
  end

  // When both banks are occupied, fp already names the older one, so the
  // bank freed by the finishing stream is naturally the next fill bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst[0]    <= B_EMPTY;
      bst[1]    <= B_EMPTY;
      mask[0]   <= '0;
      mask[1]   <= '0;
      fp        <= 1'b0;
      rd_ptr    <= 1'b0;
      cur       <= 1'b0;
      fsm       <= S_IDLE;
      t         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready_cnt <= 2'd0;
    end else begin
      bst[0]    <= bst_n[0];
      bst[1]    <= bst_n[1];
      ready_cnt <= rc_n;
      done      <= fin;
      if (wr_acc) mask[fp][wr_row] <= 1'b1;
      if (fin)    mask[cur] <= '0;
      if (cm_acc) fp <= ~fp;
      case (fsm)
        S_IDLE: if (start_acc) begin
          fsm       <= S_STREAM;
          t         <= '0;
          cur       <= rd_ptr;
          rd_ptr    <= ~rd_ptr;
          out_valid <= 1'b1;
          busy      <= 1'b1;
        end
        S_STREAM: begin
          if (fin) begin
            fsm       <= S_IDLE;
            t         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (adv) begin
            t <= t + TW'(1);
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    skew_buf_db_lane #(.BITS_AB(BITS_AB), .DIM(DIM), .LANE(r), .TW(TW)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ld),
      .clr  (fin),
      .tidx (tidx),
      .rvld (mask[sel][r]),
      .row  (mem[sel][r]),
      .aout (Aout[r])
    );
  end
endmodule

// File: tb/tb_skew_buf_db.sv
// Scoreboarded bench for skew_buf_db (DIM=4, 8-bit): stimulus pushes expected
// beats/done markers, a negedge monitor pops them as the DUT presents output.

module tb_skew_buf_db;
  localparam int DIM = 4;
  localparam int B   = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  wr_en = 1'b0;
  logic                  wr_commit = 1'b0;
  logic                  start = 1'b0;
  logic [1:0]            wr_row = '0;
  logic [DIM-1:0][B-1:0] wr_data = '0;
  logic                  wr_ready, out_valid, busy, done;
  logic [DIM-1:0][B-1:0] aout;
  logic [1:0]            ready_cnt;

  always #5 clk = ~clk;

  skew_buf_db #(.BITS_AB(B), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .wr_commit(wr_commit), .wr_ready(wr_ready),
    .start(start), .Aout(aout), .out_valid(out_valid), .busy(busy),
    .done(done), .ready_cnt(ready_cnt)
  );

  typedef struct {
    logic [DIM-1:0][B-1:0] a;
    bit                    d;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  bit   m_pov = 1'b0;
  bit   m_pen = 1'b0;

  // Hand-computed skewed beats for M[r][c] = 16r + c + 1; index [beat][lane].
  logic [7:0] full [0:6][0:3] = '{
    '{8'd1, 8'd0,  8'd0,  8'd0 },
    '{8'd2, 8'd17, 8'd0,  8'd0 },
    '{8'd3, 8'd18, 8'd33, 8'd0 },
    '{8'd4, 8'd19, 8'd34, 8'd49},
    '{8'd0, 8'd20, 8'd35, 8'd50},
    '{8'd0, 8'd0,  8'd36, 8'd51},
    '{8'd0, 8'd0,  8'd0,  8'd52}
  };

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int t, input logic [3:0] m, input logic [7:0] off);
    exp_t e;
    e.d = 1'b0;
    for (int r = 0; r < DIM; r++)
      e.a[r] = (m[r] && full[t][r] != 8'd0) ? full[t][r] + off : 8'd0;
    return e;
  endfunction

  task automatic push_beats(input logic [3:0] m, input logic [7:0] off, input int n);
    for (int t = 0; t < n; t++) sb.push_back(mk(t, m, off));
  endtask

  task automatic push_stream(input logic [3:0] m, input logic [7:0] off);
    exp_t e;
    push_beats(m, off, 7);
    e.a = '0;
    e.d = 1'b1;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string nm, input bit d);
    exp_t e;
    if (sb.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL %s: got output %h with nothing expected (t=%0t)", nm, aout, $time);
    end else begin
      e = sb.pop_front();
      chk(nm, {7'd0, d, aout}, {7'd0, e.d, e.a});
    end
  endtask

  // Monitor: a new beat is on Aout when out_valid rises or en was high last cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && (!m_pov || m_pen)) pop_cmp("beat", 1'b0);
        if (done) pop_cmp("done", 1'b1);
      end
      m_pov = out_valid;
      m_pen = en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input logic [7:0] off);
    wr_row = 2'(r);
    for (int c = 0; c < DIM; c++) wr_data[c] = 8'(16*r + c + 1) + off;
  endtask

  task automatic wr(input int r, input logic [7:0] off);
    wr_en = 1'b1;
    set_row(r, off);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    en    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", 40'(done), 40'(1));
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_aout"}, 40'(aout), 40'(0));
    chk({nm, "_ov"},   40'(out_valid), 40'(0));
    chk({nm, "_busy"}, 40'(busy), 40'(0));
    chk({nm, "_done"}, 40'(done), 40'(0));
    chk({nm, "_rcnt"}, 40'(ready_cnt), 40'(0));
    chk({nm, "_wrdy"}, 40'(wr_ready), 40'(1));
  endtask

  initial begin
    #3;
    chk_idle_outs("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Full matrix stream.
    for (int r = 0; r < DIM; r++) wr(r, 8'd0);
    commit();
    chk("full_rcnt1", 40'(ready_cnt), 40'(1));
    push_stream(4'hF, 8'd0);
    go();
    chk("full_busy", 40'(busy), 40'(1));
    chk("full_rcnt0", 40'(ready_cnt), 40'(0));
    wait_done();
    chk("full_end_ov", 40'(out_valid), 40'(0));
    chk("full_end_aout", 40'(aout), 40'(0));
    tick();
    chk("full_done_pulse", 40'(done), 40'(0));

    // Rows 1 and 3 never written.
    wr(0, 8'd0);
    wr(2, 8'd0);
    commit();
    push_stream(4'b0101, 8'd0);
    go();
    wait_done();
    tick();

    // Stall three cycles on beat 2.
    for (int r = 0; r < DIM; r++) wr(r, 8'd0);
    commit();
    push_stream(4'hF, 8'd0);
    go();
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_aout", 40'(aout), 40'(mk(2, 4'hF, 8'd0).a));
      chk("stall_ov", 40'(out_valid), 40'(1));
      tick();
    end
    en = 1'b1;
    wait_done();
    tick();

    // Ping-pong: fill bank 1 while bank 0 streams, then a blocked third fill.
    for (int r = 0; r < DIM; r++) wr(r, 8'd0);
    commit();
    push_stream(4'hF, 8'd0);
    go();
    for (int r = 0; r < DIM; r++) wr(r, 8'd64);
    commit();
    chk("pp_wrdy_blocked", 40'(wr_ready), 40'(0));
    chk("pp_rcnt1", 40'(ready_cnt), 40'(1));
    wr(0, 8'hA0);
    wait_done();
    chk("pp_wrdy_freed", 40'(wr_ready), 40'(1));
    push_stream(4'hF, 8'd64);
    go();
    chk("pp_busy2", 40'(busy), 40'(1));
    chk("pp_rcnt0", 40'(ready_cnt), 40'(0));
    wait_done();
    tick();

    // Reset at beat 3.
    for (int r = 0; r < DIM; r++) wr(r, 8'd0);
    commit();
    push_beats(4'hF, 8'd0, 4);
    go();
    repeat (3) tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst_sb_empty", 40'(sb.size()), 40'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_rcnt", 40'(ready_cnt), 40'(0));
    chk("postrst_wrdy", 40'(wr_ready), 40'(1));
    go();
    for (int i = 0; i < 3; i++) begin
      chk("postrst_ov", 40'(out_valid), 40'(0));
      chk("postrst_busy", 40'(busy), 40'(0));
      tick();
    end

    // Same-cycle last-row write and commit.
    for (int r = 0; r < 3; r++) wr(r, 8'd0);
    wr_en     = 1'b1;
    wr_commit = 1'b1;
    set_row(3, 8'd0);
    tick();
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    chk("wc_rcnt1", 40'(ready_cnt), 40'(1));
    push_stream(4'hF, 8'd0);
    go();
    wait_done();
    repeat (3) tick();
    chk("final_sb_empty", 40'(sb.size()), 40'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
